// File: rtl/calendar_counter_pkg.sv
// rtl/calendar_counter_pkg.sv - shared BCD types, limits and digit helpers for the calendar counter
package calendar_counter_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t MIN_MAX  = 8'h59;
  localparam bcd2_t HOUR_MAX = 8'h23;
  localparam bcd2_t MON_MAX  = 8'h12;
  localparam bcd2_t DAY_MIN  = 8'h01;

  localparam bcd2_t MON_JAN = 8'h01;
  localparam bcd2_t MON_FEB = 8'h02;
  localparam bcd2_t MON_MAR = 8'h03;
  localparam bcd2_t MON_APR = 8'h04;
  localparam bcd2_t MON_MAY = 8'h05;
  localparam bcd2_t MON_JUN = 8'h06;
  localparam bcd2_t MON_JUL = 8'h07;
  localparam bcd2_t MON_AUG = 8'h08;
  localparam bcd2_t MON_SEP = 8'h09;
  localparam bcd2_t MON_OCT = 8'h10;
  localparam bcd2_t MON_NOV = 8'h11;
  localparam bcd2_t MON_DEC = 8'h12;

  localparam bcd2_t DAYS_31 = 8'h31;
  localparam bcd2_t DAYS_30 = 8'h30;
  localparam bcd2_t DAYS_29 = 8'h29;
  localparam bcd2_t DAYS_28 = 8'h28;

  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] >= 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
      r[7:4] = v[7:4];
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
    logic [15:0] r;
    r[7:0]  = bcd2_inc(v[7:0]);
    r[15:8] = (v[7:0] == 8'h99) ? bcd2_inc(v[15:8]) : v[15:8];
    return r;
  endfunction

  // 10*t + o is congruent to 2*t + o modulo 4, so no binary conversion is needed.
  function automatic logic bcd2_div4(input bcd2_t v);
    return ((5'({v[7:4], 1'b0}) + 5'(v[3:0])) & 5'd3) == 5'd0;
  endfunction

endpackage

// File: rtl/calendar_counter_month_len.sv
// rtl/calendar_counter_month_len.sv - days in a BCD month, with full Gregorian leap-year rule
module calendar_counter_month_len
  import calendar_counter_pkg::*;
(
  input  logic [7:0]  mon,
  input  logic [15:0] year,
  output logic [7:0]  days
);

  logic leap;

  // Century years take the leap decision from the upper two digits.
  assign leap = (year[7:0] == 8'h00) ? bcd2_div4(year[15:8]) : bcd2_div4(year[7:0]);

  always_comb begin
    days = DAYS_31;
    case (mon)
      MON_JAN, MON_MAR, MON_MAY, MON_JUL,
      MON_AUG, MON_OCT, MON_DEC:          days = DAYS_31;
      MON_APR, MON_JUN, MON_SEP, MON_NOV: days = DAYS_30;
      MON_FEB:                            days = leap ? DAYS_29 : DAYS_28;
      default:                            days = DAYS_31;
    endcase
  end

endmodule

// File: rtl/calendar_counter.sv
// rtl/calendar_counter.sv - BCD time/date counter with tick prescaler, full carry chain and field adjust
module calendar_counter
  import calendar_counter_pkg::*;
#(
  parameter int          TICKS_PER_MIN = 60,
  parameter logic [15:0] INIT_YEAR     = 16'h2015
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       adj_min,
  input  logic       adj_hour,
  input  logic       adj_day,
  input  logic       adj_mon,
  input  logic       adj_year,
  output logic [3:0] hour0,
  output logic [3:0] hour1,
  output logic [3:0] hour2,
  output logic [3:0] hour3,
  output logic [3:0] day0,
  output logic [3:0] day1,
  output logic [3:0] mon0,
  output logic [3:0] mon1,
  output logic [3:0] year0,
  output logic [3:0] year1,
  output logic [3:0] year2,
  output logic [3:0] year3
);

  localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_MIN - 1);

  logic [7:0]  tick_cnt_q, tick_cnt_d;
  bcd2_t       min_q, min_d;
  bcd2_t       hour_q, hour_d;
  bcd2_t       day_q, day_d;
  bcd2_t       mon_q, mon_d;
  logic [15:0] year_q, year_d;

  bcd2_t       len_cur, len_adj;
  bcd2_t       mon_adj, clamp_mon;
  logic [15:0] year_adj, clamp_year;

  assign mon_adj  = (mon_q >= MON_MAX) ? MON_JAN : bcd2_inc(mon_q);
  assign year_adj = bcd4_inc(year_q);

  // Second lookup sees the month/year as they will be after an adjust, for day clamping.
  assign clamp_mon  = adj_mon ? mon_adj : mon_q;
  assign clamp_year = adj_mon ? year_q  : year_adj;

  calendar_counter_month_len u_len_cur (
    .mon  (mon_q),
    .year (year_q),
    .days (len_cur)
  );

  calendar_counter_month_len u_len_adj (
    .mon  (clamp_mon),
    .year (clamp_year),
    .days (len_adj)
  );

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    min_d      = min_q;
    hour_d     = hour_q;
    day_d      = day_q;
    mon_d      = mon_q;
    year_d     = year_q;

    if (adj_min) begin
      min_d      = (min_q >= MIN_MAX) ? 8'h00 : bcd2_inc(min_q);
      tick_cnt_d = 8'd0;
    end else if (adj_hour) begin
      hour_d = (hour_q >= HOUR_MAX) ? 8'h00 : bcd2_inc(hour_q);
    end else if (adj_day) begin
      day_d = (day_q >= len_cur) ? DAY_MIN : bcd2_inc(day_q);
    end else if (adj_mon) begin
      mon_d = mon_adj;
      if (day_q > len_adj) day_d = len_adj;
    end else if (adj_year) begin
      year_d = year_adj;
      if (day_q > len_adj) day_d = len_adj;
    end else if (tick) begin
      if (tick_cnt_q == TICK_LAST) begin
        tick_cnt_d = 8'd0;
        if (min_q >= MIN_MAX) begin
          min_d = 8'h00;
          if (hour_q >= HOUR_MAX) begin
            hour_d = 8'h00;
            if (day_q >= len_cur) begin
              day_d = DAY_MIN;
              if (mon_q >= MON_MAX) begin
                mon_d  = MON_JAN;
                year_d = year_adj;
              end else begin
                mon_d = bcd2_inc(mon_q);
              end
            end else begin
              day_d = bcd2_inc(day_q);
            end
          end else begin
            hour_d = bcd2_inc(hour_q);
          end
        end else begin
          min_d = bcd2_inc(min_q);
        end
      end else begin
        tick_cnt_d = tick_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= 8'd0;
      min_q      <= 8'h00;
      hour_q     <= 8'h00;
      day_q      <= DAY_MIN;
      mon_q      <= MON_JAN;
      year_q     <= INIT_YEAR;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      day_q      <= day_d;
      mon_q      <= mon_d;
      year_q     <= year_d;
    end
  end

  assign hour0 = min_q[3:0];
  assign hour1 = min_q[7:4];
  assign hour2 = hour_q[3:0];
  assign hour3 = hour_q[7:4];
  assign day0  = day_q[3:0];
  assign day1  = day_q[7:4];
  assign mon0  = mon_q[3:0];
  assign mon1  = mon_q[7:4];
  assign year0 = year_q[3:0];
  assign year1 = year_q[7:4];
  assign year2 = year_q[11:8];
  assign year3 = year_q[15:12];

endmodule
